// File: rtl/ansi_key_encoder.sv
// ansi_key_encoder: turns keyboard codes into the byte stream for the UART TX.
// Cursor/editing commands expand to ESC [ <param> <final> sequences; every
// other code passes through unchanged. A small FIFO absorbs keyboard bursts
// while the UART back-pressures.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no sequence in flight; output holds a passthrough byte or nothing
// S_ESC   | 8'h1B of a command sequence is on the output
// S_BRKT  | '[' (or the '3' parameter) is on the output, final byte next
// S_PARAM | '[' of CMD_DEL is on the output, '3' next
// S_FINAL | final byte is on the output; behaves like S_IDLE for loading
module ansi_key_encoder #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] CMD_UP     = 8'h80,
  parameter logic [7:0] CMD_DOWN   = 8'h81,
  parameter logic [7:0] CMD_RIGHT  = 8'h82,
  parameter logic [7:0] CMD_LEFT   = 8'h83,
  parameter logic [7:0] CMD_HOME   = 8'h84,
  parameter logic [7:0] CMD_END    = 8'h85,
  parameter logic [7:0] CMD_DEL    = 8'h86
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       keyDataInValid,
  input  logic [7:0] keyDataIn,
  output logic       keyReady,
  output logic       txDataOutValid,
  output logic [7:0] txDataOut,
  input  logic       txReady,
  output logic       seqActive
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ESC, S_BRKT, S_PARAM, S_FINAL} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [7:0]    r_data;
  logic          r_valid;
  logic [7:0]    r_cmd;

  state_t        w_state_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_valid_nxt;
  logic [7:0]    w_cmd_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_xfer;
  logic          w_slot_free;
  logic          w_fifo_nempty;
  logic [7:0]    w_head;

  function automatic logic f_is_cmd(input logic [7:0] code);
    return (code == CMD_UP)   || (code == CMD_DOWN) || (code == CMD_RIGHT) ||
           (code == CMD_LEFT) || (code == CMD_HOME) || (code == CMD_END)   ||
           (code == CMD_DEL);
  endfunction

  function automatic logic [7:0] f_final_byte(input logic [7:0] cmd);
    logic [7:0] fb;
    fb = 8'h7E;
    if      (cmd == CMD_UP)    fb = 8'h41;
    else if (cmd == CMD_DOWN)  fb = 8'h42;
    else if (cmd == CMD_RIGHT) fb = 8'h43;
    else if (cmd == CMD_LEFT)  fb = 8'h44;
    else if (cmd == CMD_HOME)  fb = 8'h48;
    else if (cmd == CMD_END)   fb = 8'h46;
    return fb;
  endfunction

  // keyReady is taken from the registered count, so a same-cycle pop never frees a full FIFO
  assign keyReady      = (r_count != DEPTH_C);
  assign w_push        = keyDataInValid & keyReady;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_xfer        = r_valid & txReady;
  assign w_slot_free   = ~r_valid | txReady;

  assign txDataOutValid = r_valid;
  assign txDataOut      = r_data;
  assign seqActive      = (r_state == S_ESC) || (r_state == S_PARAM) ||
                          (r_state == S_BRKT) || ((r_state == S_FINAL) && r_valid);

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= keyDataIn;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // sequencer state and registered output slot
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_cmd   <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_cmd   <= w_cmd_nxt;
    end
  end

  // next byte selection; only S_IDLE/S_FINAL may pop, so sequences never interleave
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_cmd_nxt   = r_cmd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE, S_FINAL: begin
        if (w_xfer) w_valid_nxt = 1'b0;
        if (w_slot_free) begin
          w_state_nxt = S_IDLE;
          if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_valid_nxt = 1'b1;
            if (f_is_cmd(w_head)) begin
              w_data_nxt  = 8'h1B;
              w_cmd_nxt   = w_head;
              w_state_nxt = S_ESC;
            end else begin
              w_data_nxt  = w_head;
            end
          end
        end
      end
      S_ESC: begin
        if (w_xfer) begin
          w_data_nxt  = 8'h5B;
          w_state_nxt = (r_cmd == CMD_DEL) ? S_PARAM : S_BRKT;
        end
      end
      S_PARAM: begin
        if (w_xfer) begin
          w_data_nxt  = 8'h33;
          w_state_nxt = S_BRKT;
        end
      end
      S_BRKT: begin
        if (w_xfer) begin
          w_data_nxt  = f_final_byte(r_cmd);
          w_state_nxt = S_FINAL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ansi_key_encoder.sv
// Bench for ansi_key_encoder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected byte streams.
module tb_ansi_key_encoder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       resetn;
  logic       keyDataInValid;
  logic [7:0] keyDataIn;
  logic       keyReady;
  logic       txDataOutValid;
  logic [7:0] txDataOut;
  logic       txReady;
  logic       seqActive;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ansi_key_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .keyDataInValid(keyDataInValid), .keyDataIn(keyDataIn), .keyReady(keyReady),
    .txDataOutValid(txDataOutValid), .txDataOut(txDataOut), .txReady(txReady),
    .seqActive(seqActive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] fin_tab [0:6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h46, 8'h7E};
  logic [7:0] fifo_q [$];
  logic [7:0] out_q [$];
  logic [7:0] exp_stream [$];
  logic [7:0] cap [$];
  int         capt [$];
  bit         m_cmd;

  function automatic bit is_cmd(input logic [7:0] c);
    return (c >= 8'h80) && (c <= 8'h86);
  endfunction

  function automatic int exp_len(input logic [7:0] c);
    if (!is_cmd(c)) return 1;
    return (c == 8'h86) ? 4 : 3;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] c, input int i);
    if (!is_cmd(c)) return c;
    if (i == 0) return 8'h1B;
    if (i == 1) return 8'h5B;
    if (c == 8'h86 && i == 2) return 8'h33;
    return fin_tab[c - 8'h80];
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] code;
    int pre;
    cyc++;
    if (!resetn) begin
      fifo_q.delete();
      out_q.delete();
      exp_stream.delete();
      cap.delete();
      capt.delete();
      m_cmd = 1'b0;
    end else begin
      if (txDataOutValid && txReady) begin
        cap.push_back(txDataOut);
        capt.push_back(cyc);
      end
      pre = fifo_q.size();
      if (out_q.size() > 0 && txReady) void'(out_q.pop_front());
      if (out_q.size() == 0 && pre > 0) begin
        code = fifo_q.pop_front();
        for (int i = 0; i < exp_len(code); i++) out_q.push_back(exp_byte(code, i));
        m_cmd = is_cmd(code);
      end
      if (keyDataInValid && pre < DEPTH) begin
        fifo_q.push_back(keyDataIn);
        for (int i = 0; i < exp_len(keyDataIn); i++) exp_stream.push_back(exp_byte(keyDataIn, i));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (resetn) begin
      check("m_valid", {31'd0, txDataOutValid}, {31'd0, out_q.size() > 0});
      if (out_q.size() > 0) check("m_data", {24'd0, txDataOut}, {24'd0, out_q[0]});
      check("m_keyReady", {31'd0, keyReady}, {31'd0, fifo_q.size() < DEPTH});
      check("m_seqActive", {31'd0, seqActive}, {31'd0, (out_q.size() > 0) && m_cmd});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] c);
    keyDataInValid = 1'b1;
    keyDataIn      = c;
    tick(1);
    keyDataInValid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((txDataOutValid || fifo_q.size() > 0) && k < 100) begin
      tick(1);
      k++;
    end
    check("drain_idle", {31'd0, txDataOutValid}, 32'd0);
  endtask

  // bytes in e are ordered first-transmitted in the most significant position
  task automatic check_stream(input string name, input int n, input logic [127:0] e);
    check({name, "_len"}, cap.size(), n);
    for (int i = 0; i < n && i < cap.size(); i++) begin
      check({name, "_byte"}, {24'd0, cap[i]}, {24'd0, e[8*(n-1-i) +: 8]});
      check({name, "_nogap"}, capt[i], capt[0] + i);
    end
  endtask

  // ---------------- directed + random tests ----------------
  initial begin
    resetn = 1'b0;
    keyDataInValid = 1'b0;
    keyDataIn = 8'h00;
    txReady = 1'b1;
    tick(3);
    resetn = 1'b1;

    check("rst_valid", {31'd0, txDataOutValid}, 32'd0);
    check("rst_data", {24'd0, txDataOut}, 32'h00);
    check("rst_seq", {31'd0, seqActive}, 32'd0);
    check("rst_keyReady", {31'd0, keyReady}, 32'd1);

    // passthrough
    cap.delete(); capt.delete();
    push(8'h41);
    check("pt_lat0", {31'd0, txDataOutValid}, 32'd0);
    push(8'h0D);
    check("pt_first", {23'd0, txDataOutValid, txDataOut}, 32'h141);
    check("pt_seq0", {31'd0, seqActive}, 32'd0);
    tick(1);
    check("pt_second", {23'd0, txDataOutValid, txDataOut}, 32'h10D);
    drain();
    check_stream("pt", 2, 128'h410D);

    // cursor up
    cap.delete(); capt.delete();
    push(8'h80);
    tick(1);
    check("up_b0", {22'd0, seqActive, txDataOutValid, txDataOut}, 32'h31B);
    tick(1);
    check("up_b1", {22'd0, seqActive, txDataOutValid, txDataOut}, 32'h35B);
    tick(1);
    check("up_b2", {23'd0, txDataOutValid, txDataOut}, 32'h141);
    drain();
    check_stream("up", 3, 128'h1B5B41);

    // delete followed immediately by a passthrough byte
    cap.delete(); capt.delete();
    push(8'h86);
    push(8'h61);
    drain();
    check_stream("del", 5, 128'h1B5B337E61);

    // back-pressure: output slot plus FIFO_DEPTH entries, sixth push dropped
    cap.delete(); capt.delete();
    txReady = 1'b0;
    push(8'h82);
    push(8'h31);
    push(8'h85);
    push(8'h32);
    push(8'h33);
    check("bp_full", {31'd0, keyReady}, 32'd0);
    push(8'h34);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {23'd0, txDataOutValid, txDataOut}, 32'h11B);
      tick(1);
    end
    check("bp_still_full", {31'd0, keyReady}, 32'd0);
    txReady = 1'b1;
    drain();
    check_stream("bp", 9, 128'h1B5B43311B5B463233);
    check("bp_ready_again", {31'd0, keyReady}, 32'd1);

    // reset in the middle of CMD_LEFT
    cap.delete(); capt.delete();
    push(8'h83);
    tick(1);
    check("rs_esc", {23'd0, txDataOutValid, txDataOut}, 32'h11B);
    tick(1);
    check("rs_brkt", {23'd0, txDataOutValid, txDataOut}, 32'h15B);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    check("rs_valid", {31'd0, txDataOutValid}, 32'd0);
    check("rs_keyReady", {31'd0, keyReady}, 32'd1);
    check("rs_seq", {31'd0, seqActive}, 32'd0);
    tick(10);
    check("rs_no_bytes", cap.size(), 0);

    // random stress
    cap.delete(); capt.delete(); exp_stream.delete();
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      keyDataInValid = ($urandom_range(0, 2) != 0);
      if (r < 4)       keyDataIn = 8'h80 + 8'($urandom_range(0, 6));
      else if (r == 4) keyDataIn = 8'h1B;
      else if (r == 5) keyDataIn = 8'($urandom_range(8'h87, 8'hFF));
      else             keyDataIn = 8'($urandom_range(0, 8'h7F));
      txReady = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    keyDataInValid = 1'b0;
    txReady = 1'b1;
    drain();
    check("rnd_len", cap.size(), exp_stream.size());
    for (int i = 0; i < cap.size() && i < exp_stream.size(); i++)
      check("rnd_stream", {24'd0, cap[i]}, {24'd0, exp_stream[i]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
